// File: rtl/mdp_ssit_maint_ctrl_if.sv
// SSIT write-port bundle shared by the maintenance controller (master) and the SSIT array (slave).
// Provides fallback values for the SSIT_SIZE / LFST_SIZE / MEMDEP_FOLDPC_WIDTH macros when the build does not set them.
`ifndef SSIT_SIZE
`define SSIT_SIZE 1024
`endif
`ifndef LFST_SIZE
`define LFST_SIZE 32
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

interface mdp_ssit_wr_if #(
   parameter int IDX_W  = $clog2(`SSIT_SIZE),
   parameter int SSID_W = $clog2(`LFST_SIZE)
) ();
   logic              o_wr_vld;
   logic              i_wr_ready;
   logic [IDX_W-1:0]  o_wr_idx;
   logic              o_wr_clear;
   logic [SSID_W-1:0] o_wr_ssid;

   modport master (
      output o_wr_vld,
      output o_wr_idx,
      output o_wr_clear,
      output o_wr_ssid,
      input  i_wr_ready
   );

   modport slave (
      input  o_wr_vld,
      input  o_wr_idx,
      input  o_wr_clear,
      input  o_wr_ssid,
      output i_wr_ready
   );
endinterface

// File: rtl/mdp_ssit_maint_ctrl.sv
// SSIT maintenance controller: arbitrates the SSIT write port between queued violation training and periodic clear sweeps.
// Define MDP_MAINT_STAT_EN to add the o_stat_drop / o_stat_sweeps statistics outputs.
`ifndef SSIT_SIZE
`define SSIT_SIZE 1024
`endif
`ifndef LFST_SIZE
`define LFST_SIZE 32
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

module mdp_ssit_maint_ctrl #(
   parameter int SSIT_SIZE      = `SSIT_SIZE,
   parameter int FOLDPC_W       = `MEMDEP_FOLDPC_WIDTH,
   parameter int SSID_W         = $clog2(`LFST_SIZE),
   parameter int CLEAR_INTERVAL = 65536,
   parameter int VQ_DEPTH       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_violation,
   input  logic [FOLDPC_W-1:0] i_vio_store_foldpc,
   input  logic [FOLDPC_W-1:0] i_vio_load_foldpc,
   input  logic                i_force_clear,
   output logic                o_vq_full,
   mdp_ssit_wr_if.master       wrIf,
   output logic                o_lfst_flush,
   output logic                o_sweep_busy
`ifdef MDP_MAINT_STAT_EN
   ,
   output logic [15:0]         o_stat_drop,
   output logic [15:0]         o_stat_sweeps
`endif
);

   localparam int IDX_W = $clog2(SSIT_SIZE);
   localparam int VQ_AW = (VQ_DEPTH > 1) ? $clog2(VQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(VQ_DEPTH + 1);
   localparam int INT_W = $clog2(CLEAR_INTERVAL);

   typedef enum logic [2:0] {
      IDLE,
      UPD_ST,
      UPD_LD,
      SWEEP,
      FLUSH
   } state_t;

   state_t             r_state;
   state_t             w_nextState;

   logic [IDX_W-1:0]   r_vqSt   [VQ_DEPTH];
   logic [IDX_W-1:0]   r_vqLd   [VQ_DEPTH];
   logic [SSID_W-1:0]  r_vqSsid [VQ_DEPTH];
   logic [VQ_AW-1:0]   r_head;
   logic [VQ_AW-1:0]   r_tail;
   logic [CNT_W-1:0]   r_vqCount;
   logic [INT_W-1:0]   r_intCnt;
   logic               r_sweepPend;
   logic [IDX_W-1:0]   r_swIdx;

   logic               w_push;
   logic               w_pop;
   logic               w_busy;
   logic               w_intHit;
   logic               w_setPend;
   logic               w_startSweep;
   logic               w_unused;

   // Only the low index/ssid bits of each folded PC matter to the SSIT.
   assign w_unused     = ^{i_vio_store_foldpc, i_vio_load_foldpc};

   assign o_vq_full    = (r_vqCount == CNT_W'(VQ_DEPTH));
   assign w_push       = i_violation && !o_vq_full;
   assign w_pop        = (r_state == UPD_LD) && wrIf.i_wr_ready;
   assign w_busy       = (r_state == SWEEP) || (r_state == FLUSH);
   assign w_intHit     = !w_busy && (r_intCnt == INT_W'(CLEAR_INTERVAL - 1));
   assign w_setPend    = w_intHit || (!w_busy && i_force_clear);
   assign w_startSweep = (r_state == IDLE) && r_sweepPend;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_vqSt[r_tail]   <= i_vio_store_foldpc[IDX_W-1:0];
         r_vqLd[r_tail]   <= i_vio_load_foldpc[IDX_W-1:0];
         r_vqSsid[r_tail] <= i_vio_store_foldpc[SSID_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_vqCount <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + VQ_AW'(1);
         if (w_pop)  r_head <= r_head + VQ_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_vqCount <= r_vqCount + CNT_W'(1);
            2'b01:   r_vqCount <= r_vqCount - CNT_W'(1);
            default: r_vqCount <= r_vqCount;
         endcase
      end
   end

   // Starting a sweep consumes any request raised in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_intCnt    <= '0;
         r_sweepPend <= 1'b0;
      end else begin
         if (!w_busy) r_intCnt <= w_intHit ? '0 : r_intCnt + INT_W'(1);
         if (w_startSweep)   r_sweepPend <= 1'b0;
         else if (w_setPend) r_sweepPend <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_swIdx <= '0;
      end else if (w_startSweep) begin
         r_swIdx <= '0;
      end else if ((r_state == SWEEP) && wrIf.i_wr_ready) begin
         r_swIdx <= r_swIdx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (r_sweepPend)          w_nextState = SWEEP;
            else if (r_vqCount != '0) w_nextState = UPD_ST;
         end
         UPD_ST: if (wrIf.i_wr_ready) w_nextState = UPD_LD;
         UPD_LD: if (wrIf.i_wr_ready) w_nextState = IDLE;
         SWEEP: begin
            if (wrIf.i_wr_ready && (r_swIdx == IDX_W'(SSIT_SIZE - 1))) w_nextState = FLUSH;
         end
         FLUSH:   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      wrIf.o_wr_vld   = 1'b0;
      wrIf.o_wr_idx   = '0;
      wrIf.o_wr_clear = 1'b0;
      wrIf.o_wr_ssid  = '0;
      o_lfst_flush    = 1'b0;
      o_sweep_busy    = w_busy;
      case (r_state)
         UPD_ST: begin
            wrIf.o_wr_vld  = 1'b1;
            wrIf.o_wr_idx  = r_vqSt[r_head];
            wrIf.o_wr_ssid = r_vqSsid[r_head];
         end
         UPD_LD: begin
            wrIf.o_wr_vld  = 1'b1;
            wrIf.o_wr_idx  = r_vqLd[r_head];
            wrIf.o_wr_ssid = r_vqSsid[r_head];
         end
         SWEEP: begin
            wrIf.o_wr_vld   = 1'b1;
            wrIf.o_wr_clear = 1'b1;
            wrIf.o_wr_idx   = r_swIdx;
         end
         FLUSH:   o_lfst_flush = 1'b1;
         default: ;
      endcase
   end

`ifdef MDP_MAINT_STAT_EN
   logic [15:0] r_statDrop;
   logic [15:0] r_statSweeps;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_statDrop   <= '0;
         r_statSweeps <= '0;
      end else begin
         if (i_violation && o_vq_full && (r_statDrop != 16'hFFFF)) r_statDrop <= r_statDrop + 16'd1;
         if (r_state == FLUSH) r_statSweeps <= r_statSweeps + 16'd1;
      end
   end

   assign o_stat_drop   = r_statDrop;
   assign o_stat_sweeps = r_statSweeps;
`endif

endmodule

// File: tb/tb_mdp_ssit_maint_ctrl.sv
// Directed self-checking bench for mdp_ssit_maint_ctrl (SSIT_SIZE=8, CLEAR_INTERVAL=20, VQ_DEPTH=4).
module tb_mdp_ssit_maint_ctrl;

   logic       clk;
   logic       rst;
   logic       violation;
   logic [7:0] stPc;
   logic [7:0] ldPc;
   logic       forceClear;
   logic       vqFull;
   logic       lfstFlush;
   logic       sweepBusy;
   int         vecCount;
   int         missCount;
   int         n;
   logic [7:0] stTab [6];
   logic [7:0] ldTab [6];
`ifdef MDP_MAINT_STAT_EN
   logic [15:0] statDrop;
   logic [15:0] statSweeps;
`endif

   mdp_ssit_wr_if #(.IDX_W(3), .SSID_W(4)) wrIf ();

   mdp_ssit_maint_ctrl #(
      .SSIT_SIZE      (8),
      .FOLDPC_W       (8),
      .SSID_W         (4),
      .CLEAR_INTERVAL (20),
      .VQ_DEPTH       (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_violation        (violation),
      .i_vio_store_foldpc (stPc),
      .i_vio_load_foldpc  (ldPc),
      .i_force_clear      (forceClear),
      .o_vq_full          (vqFull),
      .wrIf               (wrIf),
      .o_lfst_flush       (lfstFlush),
      .o_sweep_busy       (sweepBusy)
`ifdef MDP_MAINT_STAT_EN
      ,
      .o_stat_drop        (statDrop),
      .o_stat_sweeps      (statSweeps)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic vio, input logic [7:0] st, input logic [7:0] ld,
                                input logic fc, input logic rdy);
      violation       = vio;
      stPc            = st;
      ldPc            = ld;
      forceClear      = fc;
      wrIf.i_wr_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      assert (obs === exp)
      else begin
         missCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic checkBeat(input string tag, input logic [2:0] idx, input logic [3:0] ssid, input logic clr);
      checkOutput({tag, "_vld"}, wrIf.o_wr_vld, 1);
      checkOutput({tag, "_idx"}, wrIf.o_wr_idx, idx);
      checkOutput({tag, "_ssid"}, wrIf.o_wr_ssid, ssid);
      checkOutput({tag, "_clr"}, wrIf.o_wr_clear, clr);
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      stTab = '{8'h13, 8'h25, 8'h3E, 8'h47, 8'h51, 8'h6A};
      ldTab = '{8'h2A, 8'h31, 8'h4C, 8'h5D, 8'h66, 8'h7F};

      // Reset state: every output low.
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      step();
      checkOutput("rst_vld", wrIf.o_wr_vld, 0);
      checkOutput("rst_full", vqFull, 0);
      checkOutput("rst_flush", lfstFlush, 0);
      checkOutput("rst_busy", sweepBusy, 0);
      checkOutput("rst_idx", wrIf.o_wr_idx, 0);
      checkOutput("rst_clr", wrIf.o_wr_clear, 0);
      checkOutput("rst_ssid", wrIf.o_wr_ssid, 0);
`ifdef MDP_MAINT_STAT_EN
      checkOutput("rst_drop", statDrop, 0);
      checkOutput("rst_sweeps", statSweeps, 0);
`endif
      rst = 1'b0;

      // Single violation: store beat then load beat, queue drains.
      applyStimulus(1'b1, 8'h13, 8'h2A, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      checkOutput("t1_idle_vld", wrIf.o_wr_vld, 0);
      step();
      checkBeat("t1_st", 3'd3, 4'h3, 1'b0);
      step();
      checkBeat("t1_ld", 3'd2, 4'h3, 1'b0);
      step();
      checkOutput("t1_done_vld", wrIf.o_wr_vld, 0);
      step();
      checkOutput("t1_empty_vld", wrIf.o_wr_vld, 0);
      checkOutput("t1_empty_full", vqFull, 0);

      // Six back-to-back violations with the port stalled: four queue, two drop.
      doReset();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, stTab[k], ldTab[k], 1'b0, 1'b0);
         step();
         checkOutput($sformatf("t2_full_%0d", k), vqFull, (k >= 3) ? 1 : 0);
      end
      checkBeat("t2_stall", stTab[0][2:0], stTab[0][3:0], 1'b0);
`ifdef MDP_MAINT_STAT_EN
      checkOutput("t2_drop", statDrop, 2);
`endif
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkBeat($sformatf("t2_st%0d", k), stTab[k][2:0], stTab[k][3:0], 1'b0);
         step();
         checkBeat($sformatf("t2_ld%0d", k), ldTab[k][2:0], stTab[k][3:0], 1'b0);
         step();
         checkOutput($sformatf("t2_gap%0d", k), wrIf.o_wr_vld, 0);
         if (k < 3) step();
      end
      checkOutput("t2_empty_full", vqFull, 0);
      step();
      checkOutput("t2_empty_vld", wrIf.o_wr_vld, 0);

      // Automatic sweep after the idle interval.
      doReset();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      n = 0;
      while (!sweepBusy && n < 40) begin
         step();
         n++;
      end
      checkOutput("t3_start_window", (n >= 19 && n <= 22) ? 1 : 0, 1);
      for (int i = 0; i < 8; i++) begin
         checkBeat($sformatf("t3_sw%0d", i), 3'(i), 4'h0, 1'b1);
         checkOutput($sformatf("t3_busy%0d", i), sweepBusy, 1);
         checkOutput($sformatf("t3_noflush%0d", i), lfstFlush, 0);
         step();
      end
      checkOutput("t3_flush", lfstFlush, 1);
      checkOutput("t3_flush_busy", sweepBusy, 1);
      checkOutput("t3_flush_vld", wrIf.o_wr_vld, 0);
      step();
      checkOutput("t3_after_flush", lfstFlush, 0);
      checkOutput("t3_after_busy", sweepBusy, 0);
`ifdef MDP_MAINT_STAT_EN
      checkOutput("t3_sweeps", statSweeps, 1);
`endif

      // Force-clear during an update: update finishes, sweep runs, late violation waits for flush.
      doReset();
      applyStimulus(1'b1, 8'h47, 8'h5D, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      checkBeat("t4_st", 3'd7, 4'h7, 1'b0);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      step();
      checkBeat("t4_st_hold", 3'd7, 4'h7, 1'b0);
      checkOutput("t4_st_busy", sweepBusy, 0);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      checkBeat("t4_ld", 3'd5, 4'h7, 1'b0);
      step();
      checkOutput("t4_idle_vld", wrIf.o_wr_vld, 0);
      checkOutput("t4_idle_busy", sweepBusy, 0);
      step();
      checkBeat("t4_sw0", 3'd0, 4'h0, 1'b1);
      applyStimulus(1'b1, 8'h51, 8'h66, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      checkBeat("t4_sw1", 3'd1, 4'h0, 1'b1);
      for (int i = 2; i < 8; i++) step();
      checkBeat("t4_sw7", 3'd7, 4'h0, 1'b1);
      step();
      checkOutput("t4_flush", lfstFlush, 1);
      step();
      checkOutput("t4_post_vld", wrIf.o_wr_vld, 0);
      checkOutput("t4_post_busy", sweepBusy, 0);
      step();
      checkBeat("t4_late_st", 3'd1, 4'h1, 1'b0);
      step();
      checkBeat("t4_late_ld", 3'd6, 4'h1, 1'b0);

      // Stalled sweep holds its index, then reset mid-sweep abandons it without a flush.
      doReset();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      checkBeat("t5_sw0", 3'd0, 4'h0, 1'b1);
      step();
      checkBeat("t5_sw1", 3'd1, 4'h0, 1'b1);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      checkBeat("t5_hold_a", 3'd1, 4'h0, 1'b1);
      step();
      checkBeat("t5_hold_b", 3'd1, 4'h0, 1'b1);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step();
      checkBeat("t5_sw2", 3'd2, 4'h0, 1'b1);
      step();
      step();
      step();
      checkBeat("t5_sw5", 3'd5, 4'h0, 1'b1);
      rst = 1'b1;
      step();
      checkOutput("t5_rst_vld", wrIf.o_wr_vld, 0);
      checkOutput("t5_rst_busy", sweepBusy, 0);
      checkOutput("t5_rst_flush", lfstFlush, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput($sformatf("t5_noflush%0d", i), lfstFlush, 0);
         checkOutput($sformatf("t5_nobusy%0d", i), sweepBusy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
